sample_address_sequencer: RTL and testbench
===========================================

# sample_address_sequencer

Parametrised successor to the sample memory address counter: generates sample-memory addresses for recording (deserializer side) and playback (serializer side) of multi-channel interleaved audio. Tracks recorded length, supports looped or one-shot playback and frame-aligned stop, and restarts on the sampling timer. Sits between the serializer/deserializer pair, the sampling timer and the sample RAM.

## Interface
- ADDR_WIDTH, 17: width of memory_address_o.
- DEPTH, 2**17: usable words, 1 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- CHANNELS, 2: interleaved channels per frame; power of two, ≤ DEPTH.

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start pulse; accepted only in IDLE.
- mode_i  in  1  0 = record, 1 = play; sampled with start_i.
- loop_i  in  1  play wraps at end instead of stopping; read live.
- stop_i  in  1  abort current operation.
- timer_done_i  in  1  restart address at 0, state unchanged.
- deserializer_done_i  in  1  one word captured; consumed only in RECORD.
- serializer_done_i  in  1  one word consumed; consumed only in PLAY.
- memory_address_o  out  ADDR_WIDTH  current word address.
- write_enable_o  out  1  RAM write strobe.
- channel_o  out  $clog2(CHANNELS) (min 1)  memory_address_o mod CHANNELS.
- record_length_o  out  ADDR_WIDTH+1  words held by last recording.
- busy_o  out  1  state != IDLE.
- full_o  out  1  last recording filled DEPTH.
- wrapped_o  out  1  one-cycle pulse on loop wrap.
- done_o  out  1  one-cycle pulse when PLAY/RECORD ends on its own.

## Operation
- States IDLE, RECORD, PLAY. Reset: IDLE, address 0, record_length 0, full_o 0, all pulses 0.
- IDLE + start_i: address ← 0; mode_i=0 → RECORD, clears full_o; mode_i=1 → PLAY, but if record_length = 0 stay IDLE and pulse done_o.
- RECORD: write_enable_o = deserializer_done_i (combinational, same cycle, address = current). Each done: address+1. Done at address DEPTH-1 → record_length ← DEPTH, full_o ← 1, done_o pulse, IDLE.
- PLAY: each serializer_done_i advances address. Done at address record_length-1: loop_i=1 → address 0, wrapped_o pulse; loop_i=0 → done_o pulse, IDLE.
- stop_i in RECORD: record_length ← address rounded down to a multiple of CHANNELS (partial frame discarded); IDLE; no done_o. stop_i in PLAY: IDLE; no done_o. The stop cycle's deserializer_done_i still writes (write_enable_o asserted) but is not counted.
- timer_done_i in RECORD/PLAY: address ← 0; record_length unchanged; not an end event.
- Priority, same cycle: stop_i > timer_done_i > done inputs. start_i ignored outside IDLE. Done inputs ignored in IDLE and in the wrong mode. write_enable_o never asserted outside RECORD.
- Address arithmetic is ADDR_WIDTH wide and never exceeds DEPTH-1.

## Timing
- State, address, record_length, full_o: registered, updated on the clock edge after the triggering input.
- write_enable_o: combinational from deserializer_done_i and state, zero latency.
- wrapped_o, done_o: registered, high for exactly the cycle after the event.
- One word per cycle sustained: back-to-back done pulses advance address each cycle.
- reset_i mid-operation: everything returns to reset values immediately; recorded length is lost.

## Structure
- Shared package: state enum (IDLE, RECORD, PLAY), mode constants (MODE_RECORD, MODE_PLAY).
- Single module, no sub-module. Address register, length register and state are the only storage.

## Test plan
- DEPTH=8, CHANNELS=2: record, 8 deserializer_done → addresses 0..7, write_enable_o 8 times, full_o=1, record_length_o=8, done_o pulse, IDLE.
- Record 5 words, then stop_i → record_length_o=4, no done_o; play with loop_i=0, 4 serializer_done → addresses 0,1,2,3, then done_o and IDLE.
- Play with loop_i=1, record_length 4: 10 serializer_done → 0,1,2,3,0,1,2,3,0,1; wrapped_o pulses twice; busy_o stays 1.
- timer_done_i with serializer_done_i in the same cycle at address 3 → address 0, no wrap or done pulse; stop_i together with timer_done_i → IDLE.
- Play start with record_length 0 → done_o pulse, busy_o never asserts; serializer_done_i in IDLE and deserializer_done_i in PLAY → address unchanged, write_enable_o 0.
- reset_i asserted mid-record, asynchronous to clock → outputs zero immediately; after release, state IDLE and record_length_o=0.

Source files
------------

// File: rtl/sample_address_sequencer_pkg.sv
// Shared types for the sample-memory address sequencer: sequencer state and
// start-mode encodings.
package sample_address_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } seq_state_t;

    localparam logic MODE_RECORD = 1'b0;
    localparam logic MODE_PLAY   = 1'b1;

endpackage

// File: rtl/sample_address_sequencer.sv
// Sample-memory address generator for interleaved multi-channel recording
// and looped/one-shot playback, restartable by the sampling timer.
module sample_address_sequencer
    import sample_address_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH      = 2 ** 17,
    parameter int CHANNELS   = 2,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic                  loop_i,
    input  logic                  stop_i,
    input  logic                  timer_done_i,
    input  logic                  deserializer_done_i,
    input  logic                  serializer_done_i,
    output logic [ADDR_WIDTH-1:0] memory_address_o,
    output logic                  write_enable_o,
    output logic [CH_W-1:0]       channel_o,
    output logic [ADDR_WIDTH:0]   record_length_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  wrapped_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEN   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE    = (ADDR_WIDTH + 1)'(1);
    // Clears the partial-frame bits when a recording is cut short.
    localparam logic [ADDR_WIDTH:0]   FRAME_MASK = ~((ADDR_WIDTH + 1)'(CHANNELS - 1));

    seq_state_t              r_state;
    logic [ADDR_WIDTH-1:0]   r_address;
    logic [ADDR_WIDTH:0]     r_record_length;
    logic                    r_full;
    logic                    r_wrapped;
    logic                    r_done;

    logic                    w_play_last;
    logic                    w_rec_last;

    assign w_play_last = (({1'b0, r_address} + LEN_ONE) == r_record_length);
    assign w_rec_last  = (r_address == LAST_ADDR);

    // Sequencer state, address, recorded length and event pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state         <= ST_IDLE;
            r_address       <= '0;
            r_record_length <= '0;
            r_full          <= 1'b0;
            r_wrapped       <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_wrapped <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_address <= '0;
                        if (mode_i == MODE_RECORD) begin
                            r_state <= ST_RECORD;
                            r_full  <= 1'b0;
                        end else if (r_record_length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_PLAY;
                        end
                    end
                end
                ST_RECORD: begin
                    if (stop_i) begin
                        r_record_length <= {1'b0, r_address} & FRAME_MASK;
                        r_state         <= ST_IDLE;
                    end else if (timer_done_i) begin
                        r_address <= '0;
                    end else if (deserializer_done_i) begin
                        if (w_rec_last) begin
                            r_address       <= '0;
                            r_record_length <= FULL_LEN;
                            r_full          <= 1'b1;
                            r_done          <= 1'b1;
                            r_state         <= ST_IDLE;
                        end else begin
                            r_address <= r_address + ADDR_ONE;
                        end
                    end
                end
                ST_PLAY: begin
                    if (stop_i) begin
                        r_state <= ST_IDLE;
                    end else if (timer_done_i) begin
                        r_address <= '0;
                    end else if (serializer_done_i) begin
                        if (w_play_last) begin
                            r_address <= '0;
                            if (loop_i) begin
                                r_wrapped <= 1'b1;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_address <= r_address + ADDR_ONE;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_address <= '0;
                end
            endcase
        end
    end

    assign memory_address_o = r_address;
    assign write_enable_o   = (r_state == ST_RECORD) && deserializer_done_i;
    assign record_length_o  = r_record_length;
    assign busy_o           = (r_state != ST_IDLE);
    assign full_o           = r_full;
    assign wrapped_o        = r_wrapped;
    assign done_o           = r_done;

    generate
        if (CHANNELS > 1) begin : g_channel
            assign channel_o = r_address[CH_W-1:0];
        end else begin : g_single_channel
            assign channel_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sample_address_sequencer.sv
// Scoreboard bench for sample_address_sequencer with DEPTH=8, CHANNELS=2.
module tb_sample_address_sequencer;

    localparam int AW = 3;

    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_START = 7'b1000000;
    localparam logic [6:0] I_MODE  = 7'b0100000;
    localparam logic [6:0] I_LOOP  = 7'b0010000;
    localparam logic [6:0] I_STOP  = 7'b0001000;
    localparam logic [6:0] I_TIMER = 7'b0000100;
    localparam logic [6:0] I_DES   = 7'b0000010;
    localparam logic [6:0] I_SER   = 7'b0000001;

    typedef struct {
        string        tag;
        logic [AW-1:0] addr;
        logic         busy;
        logic         done;
        logic         wrap;
        logic         full;
        logic [AW:0]  len;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_s = 1'b0, mode_s = 1'b0, loop_s = 1'b0, stop_s = 1'b0;
    logic          timer_s = 1'b0, des_s = 1'b0, ser_s = 1'b0;
    logic [AW-1:0] addr_s;
    logic          we_s;
    logic [0:0]    chan_s;
    logic [AW:0]   len_s;
    logic          busy_s, full_s, wrap_s, done_s;

    int            n_checks = 0;
    int            n_fail   = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [AW-1:0] cur_addr = '0;

    sample_address_sequencer #(
        .ADDR_WIDTH(AW),
        .DEPTH     (8),
        .CHANNELS  (2)
    ) dut (
        .clock_i            (clk),
        .reset_i            (rst),
        .start_i            (start_s),
        .mode_i             (mode_s),
        .loop_i             (loop_s),
        .stop_i             (stop_s),
        .timer_done_i       (timer_s),
        .deserializer_done_i(des_s),
        .serializer_done_i  (ser_s),
        .memory_address_o   (addr_s),
        .write_enable_o     (we_s),
        .channel_o          (chan_s),
        .record_length_o    (len_s),
        .busy_o             (busy_s),
        .full_o             (full_s),
        .wrapped_o          (wrap_s),
        .done_o             (done_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pops the expectation pushed for this edge and compares.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk({mon_e.tag, ".addr"}, 32'(addr_s), 32'(mon_e.addr));
            chk({mon_e.tag, ".busy"}, 32'(busy_s), 32'(mon_e.busy));
            chk({mon_e.tag, ".done"}, 32'(done_s), 32'(mon_e.done));
            chk({mon_e.tag, ".wrap"}, 32'(wrap_s), 32'(mon_e.wrap));
            chk({mon_e.tag, ".full"}, 32'(full_s), 32'(mon_e.full));
            chk({mon_e.tag, ".len"},  32'(len_s),  32'(mon_e.len));
        end
    end

    // Drives one cycle of inputs, checks same-cycle outputs, queues the post-edge expectation.
    task automatic step(input string tag, input logic [6:0] in, input logic we_e,
                        input logic [AW-1:0] a, input logic b, input logic d,
                        input logic w, input logic f, input logic [AW:0] l);
        exp_t e;
        @(negedge clk);
        {start_s, mode_s, loop_s, stop_s, timer_s, des_s, ser_s} = in;
        #1;
        chk({tag, ".we"},  32'(we_s),   32'(we_e));
        chk({tag, ".cur"}, 32'(addr_s), 32'(cur_addr));
        chk({tag, ".ch"},  32'(chan_s), 32'(cur_addr[0]));
        e.tag = tag; e.addr = a; e.busy = b; e.done = d; e.wrap = w; e.full = f; e.len = l;
        exp_q.push_back(e);
        cur_addr = a;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst.addr", 32'(addr_s), 32'd0);
        chk("rst.busy", 32'(busy_s), 32'd0);
        chk("rst.len",  32'(len_s),  32'd0);
        rst = 1'b0;

        // Full-depth recording.
        step("rec_start", I_START, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++)
            step("rec_w", I_DES, 1'b1, (i == 7) ? 3'd0 : 3'(i + 1), i != 7, i == 7, 1'b0,
                 i == 7, (i == 7) ? 4'd8 : 4'd0);
        step("rec_idle", I_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);

        // Five words then stop (stop cycle still writes): length rounds to 4.
        step("rec2_start", I_START, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
        for (int i = 0; i < 5; i++)
            step("rec2_w", I_DES, 1'b1, 3'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
        step("rec2_stop", I_STOP | I_DES, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);

        // One-shot playback.
        step("play_start", I_START | I_MODE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 4; i++)
            step("play_r", I_SER, 1'b0, (i == 3) ? 3'd0 : 3'(i + 1), i != 3, i == 3, 1'b0,
                 1'b0, 4'd4);
        step("play_idle", I_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);

        // Looped playback: ten reads, two wraps.
        step("loop_start", I_START | I_MODE | I_LOOP, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 10; i++)
            step("loop_r", I_SER | I_LOOP, 1'b0, 3'((i + 1) % 4), 1'b1, 1'b0, (i % 4) == 3,
                 1'b0, 4'd4);
        step("loop_stop", I_STOP, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);

        // Timer beats a terminal read; stop beats timer.
        step("tmr_start", I_START | I_MODE | I_LOOP, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 3; i++)
            step("tmr_r", I_SER | I_LOOP, 1'b0, 3'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        step("tmr_ser", I_TIMER | I_SER | I_LOOP, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        step("tmr_r2", I_SER | I_LOOP, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        step("stop_tmr", I_STOP | I_TIMER, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4);

        // Zero-length recording, idle done inputs, empty play.
        step("z_start", I_START, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        step("z_w", I_DES, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        step("z_stop", I_STOP, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("idle_ser", I_SER, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("idle_des", I_DES, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("play_empty", I_START | I_MODE, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step("empty_idle", I_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Wrong-mode done and start inside PLAY are ignored.
        step("r3_start", I_START, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step("r3_w", I_DES, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step("r3_w", I_DES, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step("r3_stop", I_STOP, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step("p3_start", I_START | I_MODE, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step("play_des", I_DES, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step("play_start_ign", I_START | I_DES, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step("p3_r", I_SER, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step("p3_stop", I_STOP, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

        // Asynchronous reset in the middle of a recording.
        step("r4_start", I_START, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        for (int i = 0; i < 3; i++)
            step("r4_w", I_DES, 1'b1, 3'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        @(negedge clk);
        {start_s, mode_s, loop_s, stop_s, timer_s, des_s, ser_s} = I_DES;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.addr", 32'(addr_s), 32'd0);
        chk("arst.busy", 32'(busy_s), 32'd0);
        chk("arst.len",  32'(len_s),  32'd0);
        chk("arst.we",   32'(we_s),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        cur_addr = '0;
        step("post_rst", I_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step("post_rst2", I_NONE, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
